// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store unit with lane steering and ack timeout
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  // Last wait-counter value before giving up on the memory.
  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        acc_err;
  logic        timeout;
  logic [3:0]  be_lanes;
  logic [31:0] wdata_lanes;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [7:0]  wait_cnt;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;

  assign accept  = req_ready & req_valid;
  assign timeout = (wait_cnt == LAST_WAIT);

  // Request checks and write-side lane steering from the live request fields.
  always_comb begin
    acc_err     = 1'b0;
    be_lanes    = 4'b0000;
    wdata_lanes = req_wdata;
    case (req_size)
      SIZE_BYTE: begin
        be_lanes    = 4'b0001 << req_addr[1:0];
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        acc_err     = req_addr[0];
        be_lanes    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      SIZE_WORD: begin
        acc_err  = (req_addr[1:0] != 2'b00);
        be_lanes = 4'b1111;
      end
      default: acc_err = 1'b1;
    endcase
  end

  // Load extraction: pick the addressed lane and extend to 32 bits.
  always_comb begin
    byte_val  = mem_rdata[{lane_q, 3'b000} +: 8];
    half_val  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      SIZE_BYTE: load_data = uns_q ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
      SIZE_HALF: load_data = uns_q ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
      default:   load_data = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; mem_ack only matters while a request is outstanding.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = acc_err ? RESP : ACCESS;
      ACCESS:  if (mem_ack || timeout) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs; response fields are zero outside the RESP pulse.
  always_comb begin
    req_ready  = (state == IDLE);
    mem_req    = (state == ACCESS);
    resp_valid = (state == RESP);
    resp_err   = resp_valid & err_q;
    resp_rdata = resp_valid ? rdata_q : 32'b0;
  end

  // Request capture, wait counting and response capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'b0;
      mem_wdata <= 32'b0;
      mem_be    <= 4'b0;
      size_q    <= 2'b0;
      uns_q     <= 1'b0;
      lane_q    <= 2'b0;
      wait_cnt  <= 8'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'b0;
    end else if (accept) begin
      mem_we    <= req_we;
      mem_addr  <= {req_addr[31:2], 2'b00};
      mem_wdata <= wdata_lanes;
      mem_be    <= be_lanes;
      size_q    <= req_size;
      uns_q     <= req_unsigned;
      lane_q    <= req_addr[1:0];
      wait_cnt  <= 8'b0;
      err_q     <= acc_err;
      rdata_q   <= 32'b0;
    end else if (state == ACCESS) begin
      if (mem_ack) begin
        err_q   <= 1'b0;
        rdata_q <= mem_we ? 32'b0 : load_data;
      end else if (timeout) begin
        err_q   <= 1'b1;
        rdata_q <= 32'b0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ACK_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference model: access rules expressed arithmetically.
  function automatic logic m_err(logic [1:0] size, logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return (addr % 2) != 0;
    if (size == 2'd0) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(logic [1:0] size, logic [31:0] addr);
    int lane;
    lane = int'(addr % 4);
    if (size == 2'd2) return 4'(1 << lane);
    if (size == 2'd1) return (lane >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] size, logic [31:0] wdata);
    if (size == 2'd2) return {24'b0, wdata[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'b0, wdata[15:0]} * 32'h0001_0001;
    return wdata;
  endfunction

  function automatic logic [31:0] m_load(logic [1:0] size, logic uns, logic [31:0] addr,
                                         logic [31:0] word);
    longint v;
    longint range;
    int n;
    n = (size == 2'd2) ? 1 : (size == 2'd1) ? 2 : 4;
    range = longint'(1) << (8 * n);
    v = longint'({32'b0, word}) >> (8 * int'(addr % 4));
    v = v % range;
    if (!uns && n < 4 && v >= range / 2) v = v - range;
    return v[31:0];
  endfunction

  task automatic run_txn(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_delay, input bit noise);
    logic        e_err;
    logic [31:0] e_rd;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    int          e_cycles;
    int          req_cycles;
    bit          seen;
    e_be = m_be(size, addr);
    e_wd = m_wdata(size, wdata);
    if (m_err(size, addr)) begin
      e_cycles = 0; e_err = 1'b1; e_rd = 32'b0;
    end else if (ack_delay < TIMEOUT) begin
      e_cycles = ack_delay + 1; e_err = 1'b0;
      e_rd = we ? 32'b0 : m_load(size, uns, addr, rdata);
    end else begin
      e_cycles = TIMEOUT; e_err = 1'b1; e_rd = 32'b0;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept_ready: got %b want 1", name, req_ready);
    end
    step;
    req_valid = noise;
    req_cycles = 0;
    seen = 0;
    for (int c = 0; c < TIMEOUT + 8 && !seen; c++) begin
      if (resp_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (resp_err !== e_err) begin
          errors++; $display("FAIL %s resp_err: got %b want %b", name, resp_err, e_err);
        end
        checks++;
        if (resp_rdata !== e_rd) begin
          errors++; $display("FAIL %s resp_rdata: got %h want %h", name, resp_rdata, e_rd);
        end
        checks++;
        if (req_cycles != e_cycles || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL %s latency: got %0d req cycles (mem_req=%b) want %0d (mem_req=0)",
                   name, req_cycles, mem_req, e_cycles);
        end
      end else begin
        checks++;
        if (mem_req !== 1'b1 || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s busy: got mem_req=%b req_ready=%b want 1/0 (cycle %0d)",
                   name, mem_req, req_ready, c);
        end
        checks++;
        if (mem_addr !== {addr[31:2], 2'b00} || mem_be !== e_be || mem_we !== we ||
            (we && mem_wdata !== e_wd)) begin
          errors++;
          $display("FAIL %s mem_fields: got addr=%h be=%b we=%b wd=%h want addr=%h be=%b we=%b wd=%h",
                   name, mem_addr, mem_be, mem_we, mem_wdata, {addr[31:2], 2'b00}, e_be, we, e_wd);
        end
        req_cycles++;
        if (c == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
        if (noise) begin
          req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom;
          req_wdata = $urandom;
        end
        step;
        mem_ack = 1'b0;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s resp_missing: got no resp_valid want one", name);
    end
    req_valid = 1'b0;
    step;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_resp: got resp_valid=%b req_ready=%b want 0/1",
               name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    step; step;
    checks++;
    if ({resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b re=%b rd=%h mr=%b mw=%b ma=%h md=%h be=%b want all 0",
               resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
    end
    rstn = 1'b1;
    step;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed;
    run_txn("lb", 1'b0, 2'b10, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 2, 1'b0);
    run_txn("lhu", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1, 1'b0);
    run_txn("lh", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 1'b0);
    run_txn("sb", 1'b1, 2'b10, 1'b0, 32'h0000_3001, 32'h0000_00A5, 32'h1234_5678, 1, 1'b0);
    run_txn("sw_misaligned", 1'b1, 2'b00, 1'b0, 32'h0000_4002, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    run_txn("reserved_size", 1'b0, 2'b11, 1'b0, 32'h0000_5000, 32'h0, 32'h0, 0, 1'b0);
    run_txn("lh_odd", 1'b0, 2'b01, 1'b0, 32'h0000_6001, 32'h0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_timeout;
    run_txn("timeout", 1'b0, 2'b00, 1'b0, 32'h0000_7000, 32'h0, 32'hFFFF_FFFF, 10, 1'b0);
    run_txn("ack_last_cycle", 1'b0, 2'b00, 1'b0, 32'h0000_7004, 32'h0, 32'h0BAD_F00D,
            TIMEOUT - 1, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_CAFE;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL late_ack: got resp_valid=%b mem_req=%b want 0/0", resp_valid, mem_req);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    run_txn("b2b_0", 1'b1, 2'b00, 1'b0, 32'h0000_8000, 32'h1122_3344, 32'h0, 0, 1'b1);
    run_txn("b2b_1", 1'b0, 2'b10, 1'b1, 32'h0000_8002, 32'h0, 32'h00AB_0000, 0, 1'b1);
    run_txn("b2b_2", 1'b1, 2'b01, 1'b0, 32'h0000_8002, 32'h0000_7788, 32'h0, 3, 1'b1);
  endtask

  task automatic test_random;
    logic [1:0]  size;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'b00) addr[1:0] = 2'b00;
        if (size == 2'b01) addr[0] = 1'b0;
      end
      run_txn("random", 1'($urandom), size, 1'($urandom), addr, $urandom, $urandom,
              $urandom_range(0, 5), 1'b1);
    end
  endtask

  task automatic test_reset_mid_access;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_9000; req_wdata = 32'h0;
    step;
    req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_access_entry: got mem_req=%b want 1", mem_req);
    end
    step;
    rstn = 1'b0;
    step;
    checks++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0 || mem_addr !== 32'b0) begin
      errors++;
      $display("FAIL rst_abandon: got mem_req=%b resp_valid=%b mem_addr=%h want 0/0/0",
               mem_req, resp_valid, mem_addr);
    end
    mem_ack = 1'b1;
    rstn = 1'b1;
    step;
    mem_ack = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_resp: got resp_valid=%b mem_req=%b want 0/0", resp_valid, mem_req);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_back_to_back;
    test_random;
    test_reset_mid_access;
    run_txn("post_reset", 1'b0, 2'b01, 1'b1, 32'h0000_A006, 32'h0, 32'h8001_0000, 1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
